wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, datapath width; ADDR_W, 4, register index width (16 registers).
REQ-002 Clock and reset SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Port: Clk  input  1  rising-edge clock for all state.
REQ-004 Port: Rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: MEM_WB_MReg  input  1  write-back source select; 1 = memory data, 0 = ALU result.
REQ-006 Port: MEM_WB_EnRW  input  1  register write enable.
REQ-007 Port: MEM_WB_WN  input  4  destination register index.
REQ-008 Port: MEM_WB_ReadData  input  32  load data from the memory stage.
REQ-009 Port: MEM_WB_ALUResult  input  32  ALU result from the memory stage.
REQ-010 Port: RN1  input  4  read port 1 index (decode stage).
REQ-011 Port: RN2  input  4  read port 2 index (decode stage).
REQ-012 Port: RD1  output  32  read port 1 data.
REQ-013 Port: RD2  output  32  read port 2 data.
REQ-014 Port: WB_Data  output  32  selected write-back value, for forwarding.
REQ-015 Port: WB_Count  output  16  number of committed register writes.

Function
REQ-016 WB_Data SHALL be combinational: MEM_WB_ReadData when MEM_WB_MReg=1, else MEM_WB_ALUResult.
REQ-017 Storage SHALL be 16 x 32-bit registers R0..R15.
REQ-018 A write SHALL commit WB_Data to R[MEM_WB_WN] on the rising Clk edge when MEM_WB_EnRW=1 and MEM_WB_WN!=0.
REQ-019 R0 SHALL always read 0.
REQ-020 Writes to R0 SHALL be discarded.
REQ-021 Writes to R0 SHALL NOT increment WB_Count.
REQ-022 Reads SHALL be combinational, with zero-cycle latency from RN1/RN2 to RD1/RD2.
REQ-023 Bypass: when MEM_WB_EnRW=1, MEM_WB_WN!=0 and MEM_WB_WN==RNx, RDx SHALL equal the current WB_Data, not the stored value.
REQ-024 Bypass SHALL apply independently to both read ports.
REQ-025 When RN1==RN2, both ports SHALL return identical data.
REQ-026 MEM_WB_EnRW=0 SHALL leave all registers and WB_Count unchanged, whatever the other inputs are.
REQ-027 WB_Count SHALL increment by 1 on each committed write.
REQ-028 WB_Count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-029 X on MEM_WB_WN or data while MEM_WB_EnRW=0 SHALL NOT corrupt state.

Reset
REQ-030 Rst_n=0 SHALL immediately clear R0..R15 and WB_Count to 0, without waiting for a clock edge.
REQ-031 While Rst_n=0, RD1 and RD2 SHALL read 0, and writes and bypass SHALL be suppressed.
REQ-032 WB_Data SHALL remain the combinational mux during reset.
REQ-033 Reset deassertion SHALL be synchronous to Clk.
REQ-034 The first write SHALL commit at the first rising edge with Rst_n=1.
REQ-035 Reset asserted mid-sequence SHALL discard any write pending on that edge.

Verification
REQ-036 Reset, then RN1=3, RN2=15 -> RD1=0, RD2=0, WB_Count=0.
REQ-037 EnRW=1, MReg=0, WN=5, ALUResult=32'hDEADBEEF, one edge; then EnRW=0, RN1=5 -> RD1=32'hDEADBEEF, WB_Count=1.
REQ-038 EnRW=1, MReg=1, WN=7, ReadData=32'h12345678, RN1=RN2=7 before the edge -> RD1=RD2=32'h12345678 through bypass; R7 holds the value after the edge.
REQ-039 EnRW=1, WN=0, ALUResult=32'hFFFFFFFF, RN1=0 -> RD1=0 before and after the edge; WB_Count unchanged.
REQ-040 Preload WB_Count=16'hFFFF with 65535 writes, then one more write -> WB_Count=0.
REQ-041 Write R9=32'hA5A5A5A5, then pulse Rst_n low between edges -> R9=0 immediately; no write commits on an edge while Rst_n=0.

Source files
------------

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back stage register file: 2**ADDR_W x DATA_W registers, R0 hardwired
// to zero, two combinational read ports with write-back bypass, and a count
// of committed register writes.
//
// Ports
//   Clk               rising-edge clock for all state
//   Rst_n             asynchronous active-low reset
//   MEM_WB_MReg       write-back source: 1 = memory data, 0 = ALU result
//   MEM_WB_EnRW       register write enable
//   MEM_WB_WN         destination register index
//   MEM_WB_ReadData   load data from the memory stage
//   MEM_WB_ALUResult  ALU result from the memory stage
//   RN1 / RN2         read port indices (decode stage)
//   RD1 / RD2         read port data
//   WB_Data           selected write-back value (for forwarding)
//   WB_Count          number of committed register writes (wraps)
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              MEM_WB_MReg,
    input  logic              MEM_WB_EnRW,
    input  logic [ADDR_W-1:0] MEM_WB_WN,
    input  logic [DATA_W-1:0] MEM_WB_ReadData,
    input  logic [DATA_W-1:0] MEM_WB_ALUResult,
    input  logic [ADDR_W-1:0] RN1,
    input  logic [ADDR_W-1:0] RN2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] WB_Data,
    output logic [15:0]       WB_Count
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [15:0]       r_count;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_wr;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Write-back mux stays live during reset so forwarding paths see it.
    assign w_wb_data = MEM_WB_MReg ? MEM_WB_ReadData : MEM_WB_ALUResult;

    // Qualified write: R0 writes are dropped here so they neither store nor
    // count. EnRW is the first operand so an unknown index with EnRW=0 still
    // resolves to "no write".
    assign w_wr = MEM_WB_EnRW && (MEM_WB_WN != '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_count <= '0;
        end else if (w_wr) begin
            r_regs[MEM_WB_WN] <= w_wb_data;
            r_count           <= r_count + 16'd1;
        end
    end

    // Read ports: reset forces zero, R0 is always zero, and a matching
    // in-flight write is forwarded ahead of the stored value.
    always_comb begin
        w_rd1 = r_regs[RN1];
        if (!Rst_n || RN1 == '0)          w_rd1 = '0;
        else if (w_wr && MEM_WB_WN == RN1) w_rd1 = w_wb_data;
    end

    always_comb begin
        w_rd2 = r_regs[RN2];
        if (!Rst_n || RN2 == '0)          w_rd2 = '0;
        else if (w_wr && MEM_WB_WN == RN2) w_rd2 = w_wb_data;
    end

    assign RD1      = w_rd1;
    assign RD2      = w_rd2;
    assign WB_Data  = w_wb_data;
    assign WB_Count = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Scoreboard bench for wb_regfile. Stimulus drives inputs 1 ns after a rising
// edge and pushes the hand-computed expected outputs; a monitor on the
// falling edge pops every queued expectation and compares it to the DUT.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        Clk;
    logic        Rst_n;
    logic        MEM_WB_MReg;
    logic        MEM_WB_EnRW;
    logic [3:0]  MEM_WB_WN;
    logic [31:0] MEM_WB_ReadData;
    logic [31:0] MEM_WB_ALUResult;
    logic [3:0]  RN1;
    logic [3:0]  RN2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WB_Data;
    logic [15:0] WB_Count;

    wb_regfile #(.DATA_W(32), .ADDR_W(4)) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .MEM_WB_MReg      (MEM_WB_MReg),
        .MEM_WB_EnRW      (MEM_WB_EnRW),
        .MEM_WB_WN        (MEM_WB_WN),
        .MEM_WB_ReadData  (MEM_WB_ReadData),
        .MEM_WB_ALUResult (MEM_WB_ALUResult),
        .RN1              (RN1),
        .RN2              (RN2),
        .RD1              (RD1),
        .RD2              (RD2),
        .WB_Data          (WB_Data),
        .WB_Count         (WB_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wbd;
        logic [15:0] cnt;
        bit          chk_wbd;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so consume every pending
    // expectation on the falling edge.
    always @(negedge Clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".RD1"}, RD1, e.rd1);
            chk({e.name, ".RD2"}, RD2, e.rd2);
            chk({e.name, ".WB_Count"}, {16'h0, WB_Count}, {16'h0, e.cnt});
            if (e.chk_wbd) chk({e.name, ".WB_Data"}, WB_Data, e.wbd);
        end
    end

    task automatic drive(input logic mreg, input logic en, input logic [3:0] wn,
                         input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [3:0] rn1, input logic [3:0] rn2);
        @(posedge Clk);
        #1;
        MEM_WB_MReg      = mreg;
        MEM_WB_EnRW      = en;
        MEM_WB_WN        = wn;
        MEM_WB_ReadData  = rdata;
        MEM_WB_ALUResult = alu;
        RN1              = rn1;
        RN2              = rn2;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] wbd, input logic [15:0] cnt, input bit cw);
        exp_t e;
        e.name = nm; e.rd1 = rd1; e.rd2 = rd2; e.wbd = wbd; e.cnt = cnt; e.chk_wbd = cw;
        q.push_back(e);
    endtask

    initial begin
        // Reset state; write-back mux still live during reset.
        Rst_n = 1'b0;
        MEM_WB_MReg = 1'b1; MEM_WB_EnRW = 1'b1; MEM_WB_WN = 4'd3;
        MEM_WB_ReadData = 32'h0000_0055; MEM_WB_ALUResult = 32'h0;
        RN1 = 4'd3; RN2 = 4'd15;
        expect_out("reset", 32'h0, 32'h0, 32'h0000_0055, 16'h0, 1'b1);
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1; MEM_WB_EnRW = 1'b0;

        // ALU write to R5, bypass on port 2 only.
        drive(1'b0, 1'b1, 4'd5, 32'h0, 32'hDEAD_BEEF, 4'd3, 4'd5);
        expect_out("wr5_bypass", 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd0, 1'b1);
        drive(1'b0, 1'b0, 4'd5, 32'h0, 32'h0, 4'd5, 4'd0);
        expect_out("rd5", 32'hDEAD_BEEF, 32'h0, 32'h0, 16'd1, 1'b1);

        // Memory write to R7, both ports on the same index via bypass.
        drive(1'b1, 1'b1, 4'd7, 32'h1234_5678, 32'hCAFE_0000, 4'd7, 4'd7);
        expect_out("wr7_bypass", 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 16'd1, 1'b1);

        // Disabled write with unknown index/data must not disturb anything.
        drive(1'b0, 1'b0, 4'bxxxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 4'd7, 4'd5);
        expect_out("rd7_xin", 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 16'd2, 1'b0);

        // R0 write discarded, no bypass, no count.
        drive(1'b0, 1'b1, 4'd0, 32'h0, 32'hFFFF_FFFF, 4'd0, 4'd7);
        expect_out("wr0", 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 16'd2, 1'b1);
        drive(1'b0, 1'b0, 4'd5, 32'h0, 32'h1111_1111, 4'd0, 4'd5);
        expect_out("rd0_after", 32'h0, 32'hDEAD_BEEF, 32'h1111_1111, 16'd2, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd5, 4'd0);
        expect_out("en0_noop", 32'hDEAD_BEEF, 32'h0, 32'h0, 16'd2, 1'b1);

        // Independent bypass per port.
        drive(1'b0, 1'b1, 4'd5, 32'h0, 32'h0BAD_F00D, 4'd5, 4'd7);
        expect_out("byp_p1", 32'h0BAD_F00D, 32'h1234_5678, 32'h0BAD_F00D, 16'd2, 1'b1);
        drive(1'b0, 1'b1, 4'd7, 32'h0, 32'h7777_7777, 4'd5, 4'd7);
        expect_out("byp_p2", 32'h0BAD_F00D, 32'h7777_7777, 32'h7777_7777, 16'd3, 1'b1);

        // R9 write, then a reset pulse entirely between edges.
        drive(1'b0, 1'b1, 4'd9, 32'h0, 32'hA5A5_A5A5, 4'd0, 4'd0);
        expect_out("wr9", 32'h0, 32'h0, 32'hA5A5_A5A5, 16'd4, 1'b1);
        drive(1'b0, 1'b0, 4'd9, 32'h0, 32'h0, 4'd9, 4'd7);
        expect_out("rd9", 32'hA5A5_A5A5, 32'h7777_7777, 32'h0, 16'd5, 1'b1);
        drive(1'b0, 1'b1, 4'd9, 32'h0, 32'h0000_1111, 4'd9, 4'd9);
        Rst_n = 1'b0;
        expect_out("rst_pulse", 32'h0, 32'h0, 32'h0000_1111, 16'd0, 1'b1);
        @(negedge Clk);
        #2;
        Rst_n = 1'b1; MEM_WB_EnRW = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd9, 4'd5);
        expect_out("after_pulse", 32'h0, 32'h0, 32'h0, 16'd0, 1'b1);

        // Reset held across an edge with a pending write; the first edge
        // after release commits.
        drive(1'b0, 1'b1, 4'd4, 32'h0, 32'h0000_0044, 4'd4, 4'd0);
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        expect_out("rel_bypass", 32'h0000_0044, 32'h0, 32'h0000_0044, 16'd0, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd4, 4'd0);
        expect_out("rel_commit", 32'h0000_0044, 32'h0, 32'h0, 16'd1, 1'b1);

        // Count wrap: clear, 65535 writes to R1, then one more.
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0);
        Rst_n = 1'b0;
        #2;
        Rst_n = 1'b1;
        for (int i = 0; i < 65535; i++)
            drive(1'b0, 1'b1, 4'd1, 32'h0, 32'(i), 4'd0, 4'd0);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd1, 4'd0);
        expect_out("cnt_ffff", 32'h0000_FFFE, 32'h0, 32'h0, 16'hFFFF, 1'b1);
        drive(1'b0, 1'b1, 4'd2, 32'h0, 32'h0000_0002, 4'd1, 4'd2);
        expect_out("wrap_wr", 32'h0000_FFFE, 32'h0000_0002, 32'h0000_0002, 16'hFFFF, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd2, 4'd1);
        expect_out("cnt_wrap", 32'h0000_0002, 32'h0000_FFFE, 32'h0, 16'h0000, 1'b1);

        // Drain: every expectation must have been consumed by the monitor.
        repeat (3) @(posedge Clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
